// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the RV32I program loader: instruction kinds, opcodes and loader FSM states.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    KIND_LW      = 3'd0,
    KIND_SW      = 3'd1,
    KIND_RTYPE   = 3'd2,
    KIND_BEQ     = 3'd3,
    KIND_ITYPE   = 3'd4,
    KIND_JAL     = 3'd5,
    KIND_JALR    = 3'd6,
    KIND_ILLEGAL = 3'd7
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ZERO = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when imm[20:lsb] are all copies of one bit, i.e. the value sign-extends from bit lsb.
  function automatic logic upper_bits_equal(input logic [20:0] imm, input int lsb);
    logic signed [20:0] s;
    s = $signed(imm) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encode_comb.sv
// Purely combinational RV32I encoder: instruction kind plus operand fields -> machine word and legality.
module instr_encode_comb
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        f7b5_i,
  input  logic [20:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_ok_o,
  output logic        illegal_o
);

  kind_e kind;
  logic  is_shift;

  assign kind     = kind_e'(kind_i);
  assign is_shift = (funct3_i == F3_SLL) || (funct3_i == F3_SRX);

  always_comb begin
    word_o     = '0;
    range_ok_o = 1'b1;
    illegal_o  = 1'b0;
    case (kind)
      KIND_LW: begin
        word_o     = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
        range_ok_o = upper_bits_equal(imm_i, 11);
      end
      KIND_SW: begin
        word_o     = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
        range_ok_o = upper_bits_equal(imm_i, 11);
      end
      KIND_RTYPE: begin
        word_o = {1'b0, f7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_OP};
      end
      KIND_BEQ: begin
        word_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_ZERO,
                      imm_i[4:1], imm_i[11], OP_BRANCH};
        range_ok_o = upper_bits_equal(imm_i, 12) && !imm_i[0];
      end
      KIND_ITYPE: begin
        // Shifts carry a 5-bit shamt; the upper immediate bits are not part of the word.
        if (is_shift) begin
          word_o = {1'b0, f7b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_OPIMM};
        end else begin
          word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_OPIMM};
          range_ok_o = upper_bits_equal(imm_i, 11);
        end
      end
      KIND_JAL: begin
        word_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        range_ok_o = !imm_i[0];
      end
      KIND_JALR: begin
        word_o     = {imm_i[11:0], rs1_i, F3_ZERO, rd_i, OP_JALR};
        range_ok_o = upper_bits_equal(imm_i, 11);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction beats and streams them as sequential instruction-memory writes.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          CW        = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic          in_f7b5,
  input  logic [20:0]   in_imm,
  output logic          wr_valid,
  input  logic          mem_ready,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          done,
  output logic [CW-1:0] word_count,
  output logic          err_illegal,
  output logic          err_range,
  output logic          err_overflow
);

  state_e        state_q, state_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_ill_q, err_ill_d;
  logic          err_rng_q, err_rng_d;
  logic          err_ovf_q, err_ovf_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        enc_illegal;
  logic        in_load;
  logic        full;
  logic        accept;
  logic        good;
  logic        fire;

  instr_encode_comb u_encode (
    .kind_i     (in_kind),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .f7b5_i     (in_f7b5),
    .imm_i      (in_imm),
    .word_o     (enc_word),
    .range_ok_o (enc_ok),
    .illegal_o  (enc_illegal)
  );

  assign in_load = (state_q == ST_LOAD);
  assign full    = (acc_q == CW'(MAX_WORDS));
  // A restart throws away everything in flight, so no beat is claimed in a start cycle.
  assign in_ready = in_load && !full && (!valid_q || mem_ready) && !start;
  assign accept   = in_valid && in_ready;
  assign good     = accept && enc_ok && !enc_illegal;
  assign fire     = valid_q && mem_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_ill_d = err_ill_q;
    err_rng_d = err_rng_q;
    err_ovf_d = err_ovf_q;

    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_LOAD:  if (finish) state_d = ST_DRAIN;
      ST_DRAIN: if (!valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (fire) begin
      count_d = count_q + CW'(1);
      addr_d  = addr_q + 32'd4;
      valid_d = 1'b0;
    end

    // Rejected beats are consumed but never occupy the output register or a capacity slot.
    if (good) begin
      data_d  = enc_word;
      valid_d = 1'b1;
      acc_d   = acc_q + CW'(1);
    end
    if (accept && enc_illegal) err_ill_d = 1'b1;
    if (accept && !enc_illegal && !enc_ok) err_rng_d = 1'b1;
    if (in_load && full && in_valid && !start) err_ovf_d = 1'b1;

    if (start) begin
      state_d   = ST_LOAD;
      acc_d     = '0;
      count_d   = '0;
      addr_d    = BASE_ADDR;
      data_d    = '0;
      valid_d   = 1'b0;
      err_ill_d = 1'b0;
      err_rng_d = 1'b0;
      err_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_ill_q <= 1'b0;
      err_rng_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_ill_q <= err_ill_d;
      err_rng_q <= err_rng_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign wr_valid     = valid_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign done         = (state_q == ST_DONE);
  assign word_count   = count_q;
  assign err_illegal  = err_ill_q;
  assign err_range    = err_rng_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: takes an instruction class plus operand fields and encodes a legal RV32I machine word for the single-cycle core's instruction memory.
- Sequentially streams the encoded words into consecutive instruction-memory words starting at BASE_ADDR.
- Used as a boot/program loader and as a directed-stimulus source for core verification.
- Valid/ready on input, valid/ready on the memory write port, 1-entry output register, sticky error flags.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MAX_WORDS, 64, capacity in words; loader refuses beats beyond this.
- CW, 7, width of word_count; must satisfy 2^CW > MAX_WORDS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin/restart a load session
- finish  in  1  pulse: no more instructions; drain and complete
- in_valid  in  1  instruction beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_kind  in  3  0=LW 1=SW 2=RTYPE 3=BEQ 4=ITYPE 5=JAL 6=JALR 7=illegal
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3  used by RTYPE/ITYPE only
- in_f7b5  in  1  funct7[5] for RTYPE and ITYPE shifts
- in_imm  in  21  signed immediate, byte offset for BEQ/JAL
- wr_valid  out  1  memory write request
- mem_ready  in  1  memory accepts write this cycle
- wr_addr  out  32  byte address
- wr_data  out  32  encoded instruction
- done  out  1  high in DONE state
- word_count  out  CW  words written this session
- err_illegal  out  1  sticky: kind 7 received
- err_range  out  1  sticky: immediate not encodable
- err_overflow  out  1  sticky: in_valid while full in LOAD

Behaviour:
- Reset (async): state IDLE; all outputs 0; wr_addr=BASE_ADDR; output register empty.
- States:
  - IDLE: start -> LOAD.
  - LOAD: finish -> DRAIN.
  - DRAIN: output register empty -> DONE.
  - DONE: start -> LOAD.
  - start in any state clears word_count, the accepted-count, all err flags and the output register, and enters LOAD. start wins over a simultaneous finish.
- in_ready = (state==LOAD) & !full & (!wr_valid | mem_ready). full = accepted-count == MAX_WORDS.
- On an accepted beat, encode combinationally and register the result.
  - wr_valid rises the next cycle (latency 1).
  - wr_data/wr_addr hold stable while wr_valid & !mem_ready.
- Write handshake (wr_valid & mem_ready):
  - word_count+1; wr_addr+4 after the beat.
  - wr_valid drops unless a new beat is accepted in the same cycle.
  - Back-to-back throughput is 1 word/cycle.
- Encodings (opcode in [6:0]):
  - LW: imm[11:0],rs1,010,rd,0000011.
  - SW: imm[11:5],rs2,rs1,010,imm[4:0],0100011.
  - RTYPE: 0,f7b5,00000,rs2,rs1,funct3,rd,0110011.
  - BEQ: imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011.
  - ITYPE: imm[11:0],rs1,funct3,rd,0010011; when funct3 is 001 or 101, bits[31:25] are 0,f7b5,00000 and only imm[4:0] is used.
  - JAL: imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111.
  - JALR: imm[11:0],rs1,000,rd,1100111.
- Range rules (checked at acceptance):
  - LW/SW/ITYPE(non-shift)/JALR: imm[20:11] must all be equal.
  - BEQ: imm[20:12] must all be equal and imm[0]=0.
  - JAL: imm[0]=0.
- A beat that fails a range rule or has kind 7:
  - is consumed (in_ready handshake completes);
  - sets the matching sticky flag;
  - produces no write and does not count toward full.
- err_overflow is set when in_valid=1 in LOAD while full. The beat is not accepted.
- in_valid outside LOAD is ignored with no flags set.
- finish with a beat accepted in the same cycle: the beat is written, then DONE.
- done stays high until start or reset.
- Reset mid-operation: any pending write is dropped and wr_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - the in_kind encodings;
  - the RV32I opcodes (7'b0000011, 0100011, 0110011, 1100011, 0010011, 1101111, 1100111), also used by main_decoder;
  - the FSM state encoding.
- One natural sub-module: instr_encode_comb, purely combinational (kind, fields, imm -> word, range_ok, illegal).
- Top level holds the FSM, counters, output register and flags.

Test Plan:
- Reset, start, then a beat with LW rd=5 rs1=2 imm=8 -> next cycle wr_valid=1, wr_addr=0x0, wr_data=0x00812283; word_count=1 after handshake.
- Stream SW rs1=2 rs2=6 imm=-4, BEQ rs1=1 rs2=2 imm=-8, JAL rd=1 imm=2048 with mem_ready=1:
  - data 0xFE612E23, 0xFE208CE3, 0x001000EF;
  - addrs 0x0, 0x4, 0x8 on consecutive cycles.
- Hold mem_ready=0 for 3 cycles with a second beat pending:
  - wr_addr/wr_data stable throughout;
  - in_ready=0;
  - no lost or duplicated words (word_count=2 at end).
- Out-of-range beats:
  - BEQ imm=5 -> err_range=1, no write, word_count unchanged.
  - kind 7 -> err_illegal=1.
  - start -> both flags clear.
- MAX_WORDS=4: send 5 beats -> 4 writes, in_ready=0 after the 4th, err_overflow=1; finish -> done=1 once drained.
- Assert rst_n low while wr_valid=1 and mem_ready=0 -> wr_valid=0 immediately, state IDLE, wr_addr=BASE_ADDR.
